// File: rtl/sram_like_data_ram.sv
// sram_like_data_ram: responder for the CPU's sram-like data port, also usable
// as on-chip scratch RAM. 2**ADDR_W 32-bit words, byte-lane writes, fixed
// LATENCY from the addr handshake to data_ok, in-order responses, and at most
// MAX_OUTSTANDING accepted-but-unanswered requests.
// Optional feature: define SRAM_LIKE_RAM_STALL_EN to add LFSR-driven random
// addr_ok stalls (about 25 percent of cycles) for handshake stress testing.
module sram_like_data_ram #(
    parameter int ADDR_W          = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0]  word_idx;
    logic [3:0]         be;
    logic               accept;
    logic               stall;
    logic               unused_addr_bits;

    logic               alive_q, alive_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]        pdata_q [LATENCY];
    logic [31:0]        pdata_d [LATENCY];
    logic               data_ok_q, data_ok_d;
    logic [31:0]        rdata_q, rdata_d;

    // Lane mask for a request; reserved size 3 writes nothing.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign word_idx         = data_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^data_addr[31:ADDR_W+2];
    assign be               = byte_enable(data_size, data_addr[1:0]);

`ifdef SRAM_LIKE_RAM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advances every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register, seeded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // alive_q keeps addr_ok low while reset is held and for the release edge.
    assign data_addr_ok = alive_q & (cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~stall;
    assign accept       = data_req & data_addr_ok;

    // Next-state for the response pipeline, the output stage and the counter.
    always_comb begin
        alive_d = 1'b1;
        vld_d   = '0;
        for (int i = 0; i < LATENCY; i++) pdata_d[i] = pdata_q[i];
        vld_d[0]   = accept;
        pdata_d[0] = mem_q[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            pdata_d[i] = pdata_q[i-1];
        end
        data_ok_d = vld_q[LATENCY-1];
        rdata_d   = vld_q[LATENCY-1] ? pdata_q[LATENCY-1] : 32'h0;
        case ({accept, data_ok_q})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: cleared asynchronously so in-flight responses vanish on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q   <= 1'b0;
            cnt_q     <= '0;
            vld_q     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            alive_q   <= alive_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // Pipeline payload carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) pdata_q[i] <= pdata_d[i];
    end

    // Array write on the accept edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_data_ram.sv
// Bench for sram_like_data_ram: main instance (LATENCY=2, MAX_OUTSTANDING=2)
// checked through a response scoreboard, plus a MAX_OUTSTANDING=1 instance for
// the throttling behaviour.
module tb_sram_like_data_ram;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_addr_ok, d_data_ok;

    logic        r1_req, r1_wr;
    logic [1:0]  r1_size;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        r1_addr_ok, r1_data_ok;

    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];

    sram_like_data_ram #(.ADDR_W(10), .LATENCY(LAT), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst_n), .data_req(d_req), .data_wr(d_wr), .data_size(d_size),
        .data_addr(d_addr), .data_wdata(d_wdata), .data_rdata(d_rdata),
        .data_addr_ok(d_addr_ok), .data_data_ok(d_data_ok)
    );

    sram_like_data_ram #(.ADDR_W(10), .LATENCY(LAT), .MAX_OUTSTANDING(1)) dut1 (
        .clk(clk), .rst(rst_n), .data_req(r1_req), .data_wr(r1_wr), .data_size(r1_size),
        .data_addr(r1_addr), .data_wdata(r1_wdata), .data_rdata(r1_rdata),
        .data_addr_ok(r1_addr_ok), .data_data_ok(r1_data_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Monitor: every data_ok pops the oldest expectation and checks data and timing.
    always @(negedge clk) begin
        if (d_data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_data_ok: got data_ok=1 rdata=%h at cycle %0d, required no response", d_rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) check({e.name, "_rdata"}, d_rdata, e.data);
                check_int({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Drive one request from a negedge until accepted, queueing its expected response.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expd, input bit chk,
                         input bit push, input string name);
        bit acc = 0;
        d_req = 1'b1; d_wr = wr; d_size = size; d_addr = addr; d_wdata = wdata;
        for (int n = 0; n < 20 && !acc; n++) begin
            if (d_addr_ok === 1'b1) begin
                acc = 1;
                if (push) begin
                    exp_t e;
                    e.data = expd; e.chk = chk; e.cyc = cyc + 1 + LAT; e.name = name;
                    sb.push_back(e);
                end
            end
            @(negedge clk);
        end
        d_req = 1'b0;
        if (!acc) begin
            tests++;
            failed++;
            $display("FAIL %s_accept: got no addr_ok within 20 cycles, required accept", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL %s_drain: got %0d responses pending, required 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a1 = -1, a2 = -1, d1 = -1, d2 = -1;
        bit okhigh_full = 0;

        rst_n = 1'b0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        r1_req = 0; r1_wr = 0; r1_size = 2'd2; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_addr_ok", {31'h0, d_addr_ok}, 32'h0);
        check("rst_data_ok", {31'h0, d_data_ok}, 32'h0);
        check("rst_rdata", d_rdata, 32'h0);
        check("rst_addr_ok_m1", {31'h0, r1_addr_ok}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("addr_ok_after_rst", {31'h0, d_addr_ok}, 32'h1);

        // MAX_OUTSTANDING=1: two reads held on req.
        r1_req = 1'b1;
        for (int n = 0; n < 40 && a2 < 0; n++) begin
            if (r1_data_ok === 1'b1 && d1 < 0) d1 = cyc;
            if (a1 >= 0 && cyc > a1 && (d1 < 0 || cyc == d1) && r1_addr_ok === 1'b1) okhigh_full = 1;
            if (r1_req && r1_addr_ok === 1'b1) begin
                if (a1 < 0) a1 = cyc;
                else        a2 = cyc;
            end
            @(negedge clk);
        end
        r1_req = 1'b0;
        for (int n = 0; n < 10 && d2 < 0; n++) begin
            if (r1_data_ok === 1'b1) d2 = cyc;
            if (d2 < 0) @(negedge clk);
        end
        check_int("m1_first_data_ok", d1, a1 + 1 + LAT);
        check_int("m1_second_accept", a2, d1 + 1);
        check_int("m1_addr_ok_while_full", int'(okhigh_full), 0);
        check_int("m1_second_data_ok", d2, a2 + 1 + LAT);
        @(negedge clk);

        // Word write then read back.
        issue(1, 2'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 0, 1, "sw_10");
        issue(0, 2'd2, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 1, 1, "lw_10");
        // Byte to lane 2, half to low lanes; writes return the old word.
        issue(1, 2'd0, 32'h0000_0012, 32'h0055_0000, 32'hDEADBEEF, 1, 1, "sb_12");
        issue(1, 2'd1, 32'h0000_0010, 32'h0000_1234, 32'hDE55BEEF, 1, 1, "sh_10");
        issue(0, 2'd2, 32'h0000_0010, 32'h0, 32'hDE551234, 1, 1, "lw_10_sub");
        drain("subword");

        // Back-to-back reads, in-order responses.
        issue(1, 2'd2, 32'h0, 32'hA0A0_0000, 32'h0, 0, 1, "sw_0");
        issue(1, 2'd2, 32'h4, 32'hA4A4_0004, 32'h0, 0, 1, "sw_4");
        issue(1, 2'd2, 32'h8, 32'hA8A8_0008, 32'h0, 0, 1, "sw_8");
        drain("fill");
        issue(0, 2'd2, 32'h0, 32'h0, 32'hA0A0_0000, 1, 1, "lw_0");
        issue(0, 2'd2, 32'h4, 32'h0, 32'hA4A4_0004, 1, 1, "lw_4");
        check("addr_ok_full", {31'h0, d_addr_ok}, 32'h0);
        issue(0, 2'd2, 32'h8, 32'h0, 32'hA8A8_0008, 1, 1, "lw_8");
        drain("b2b");

        // Alias of word 0 and reserved-size write.
        issue(1, 2'd2, 32'h0000_1000, 32'h0000_0001, 32'hA0A0_0000, 1, 1, "sw_alias");
        issue(1, 2'd3, 32'h0000_0004, 32'hFFFF_FFFF, 32'hA4A4_0004, 1, 1, "sz3_4");
        issue(0, 2'd2, 32'h0000_0000, 32'h0, 32'h0000_0001, 1, 1, "lw_alias");
        issue(0, 2'd2, 32'h0000_0004, 32'h0, 32'hA4A4_0004, 1, 1, "lw_4_kept");
        drain("alias");

        // Reset while a read is in flight: its response must never appear.
        issue(0, 2'd2, 32'h0000_0010, 32'h0, 32'h0, 0, 0, "lw_dropped");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data_ok", {31'h0, d_data_ok}, 32'h0);
        check("midrst_addr_ok", {31'h0, d_addr_ok}, 32'h0);
        repeat (3) @(negedge clk);
        check("midrst_addr_ok_held", {31'h0, d_addr_ok}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 2'd2, 32'h0000_0010, 32'h0, 32'hDE551234, 1, 1, "lw_10_post_rst");
        issue(0, 2'd2, 32'h0000_0000, 32'h0, 32'h0000_0001, 1, 1, "lw_0_post_rst");
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
